// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient serializer FSM states and the tap-to-coefficient helper.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } fir_state_e;

    // A symmetric filter with an odd tap count stores only the unique half plus the centre tap.
    function automatic int ncoeffs(input int n_taps);
        return (n_taps + 1) / 2;
    endfunction

endpackage

// File: rtl/coeff_bank.sv
// Coefficient storage with address-checked write port and a write-through snapshot for download.
// Optional readback port enabled by COEFF_SERIALIZER_READBACK_EN.
module coeff_bank #(
    parameter int DataWidth = 12,
    parameter int NCoeffs   = 5,
    parameter int AddrWidth = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [AddrWidth-1:0]          wr_addr,
    input  logic [DataWidth-1:0]          wr_data,
    output logic                          addr_valid,
`ifdef COEFF_SERIALIZER_READBACK_EN
    input  logic [AddrWidth-1:0]          rd_addr,
    output logic [DataWidth-1:0]          rd_data,
`endif
    output logic [NCoeffs*DataWidth-1:0]  snapshot
);

    localparam logic [AddrWidth:0] AddrLimit = (AddrWidth + 1)'(NCoeffs);

    logic [DataWidth-1:0] words [NCoeffs];
    logic                 wr_fire;

    assign addr_valid = ({1'b0, wr_addr} < AddrLimit);
    assign wr_fire    = wr_en && addr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCoeffs; i++) begin
                words[i] <= '0;
            end
        end else if (wr_fire) begin
            words[wr_addr] <= wr_data;
        end
    end

    // The snapshot forwards a same-cycle write so a download started alongside it sends the new word.
    always_comb begin
        snapshot = '0;
        for (int i = 0; i < NCoeffs; i++) begin
            snapshot[i*DataWidth +: DataWidth] =
                (wr_fire && (int'(wr_addr) == i)) ? wr_data : words[i];
        end
    end

`ifdef COEFF_SERIALIZER_READBACK_EN
    assign rd_data = ({1'b0, rd_addr} < AddrLimit) ? words[rd_addr] : '0;
`endif

endmodule

// File: rtl/coeff_serializer.sv
// Loads a coefficient bank and streams it bit-serially into the FIR filter, word NCoeffs-1 first, MSB first.
// Defining COEFF_SERIALIZER_READBACK_EN adds the rd_addr/rd_data readback port.
module coeff_serializer
    import fir_pkg::*;
#(
    parameter int  DataWidth = 12,
    parameter int  NTaps     = 9,
    localparam int NCoeffs   = ncoeffs(NTaps),
    localparam int AddrWidth = (NCoeffs > 1) ? $clog2(NCoeffs) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    output logic                 wr_err,
    input  logic                 load_req,
    input  logic                 fir_busy,
`ifdef COEFF_SERIALIZER_READBACK_EN
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data,
`endif
    output logic                 busy,
    output logic                 load_done,
    output logic                 coeff_load_out,
    output logic                 coeff_out
);

    localparam int TotalBits = NCoeffs * DataWidth;
    localparam int BitWidth  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [BitWidth-1:0]  BitMax  = BitWidth'(DataWidth - 1);
    localparam logic [AddrWidth-1:0] WordMax = AddrWidth'(NCoeffs - 1);

    generate
        if (NTaps % 2 == 0) begin : g_even_ntaps
            $error("coeff_serializer: NTaps must be odd");
        end
    endgenerate

    fir_state_e             state;
    logic [TotalBits-1:0]   shreg;
    logic [TotalBits-1:0]   snapshot;
    logic [BitWidth-1:0]    bit_cnt;
    logic [AddrWidth-1:0]   word_cnt;
    logic                   addr_valid;
    logic                   bank_wr_en;
    logic                   start_shift;
    logic                   last_bit;

    assign bank_wr_en  = wr_en && (state == IDLE);
    assign start_shift = ((state == IDLE) && load_req && !fir_busy) ||
                         ((state == WAIT) && !fir_busy);
    assign last_bit    = (word_cnt == '0) && (bit_cnt == '0);

    coeff_bank #(
        .DataWidth (DataWidth),
        .NCoeffs   (NCoeffs),
        .AddrWidth (AddrWidth)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bank_wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr_valid (addr_valid),
`ifdef COEFF_SERIALIZER_READBACK_EN
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`endif
        .snapshot   (snapshot)
    );

    // The counters track the bit currently on coeff_out, so word 0 bit 0 marks the final SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            wr_err         <= 1'b0;
            load_done      <= 1'b0;
            coeff_load_out <= 1'b0;
            coeff_out      <= 1'b0;
            shreg          <= '0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
        end else begin
            wr_err    <= wr_en && ((state != IDLE) || !addr_valid);
            load_done <= 1'b0;
            if (start_shift) begin
                state          <= SHIFT;
                busy           <= 1'b1;
                coeff_load_out <= 1'b1;
                coeff_out      <= snapshot[TotalBits-1];
                shreg          <= {snapshot[TotalBits-2:0], 1'b0};
                bit_cnt        <= BitMax;
                word_cnt       <= WordMax;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_req) begin
                            state <= WAIT;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        busy <= 1'b1;
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            state          <= DONE;
                            coeff_load_out <= 1'b0;
                            coeff_out      <= 1'b0;
                            load_done      <= 1'b1;
                        end else begin
                            coeff_out <= shreg[TotalBits-1];
                            shreg     <= {shreg[TotalBits-2:0], 1'b0};
                            if (bit_cnt == '0) begin
                                bit_cnt  <= BitMax;
                                word_cnt <= word_cnt - 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coeff_serializer.sv
// Directed plus randomized bench for coeff_serializer against a bank/bitstream reference model.
module tb_coeff_serializer;

    localparam int DataWidth = 12;
    localparam int NTaps     = 9;
    localparam int NCoeffs   = 5;
    localparam int AddrWidth = 3;
    localparam int TotalBits = NCoeffs * DataWidth;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 wr_err;
    logic                 load_req;
    logic                 fir_busy;
    logic                 busy;
    logic                 load_done;
    logic                 coeff_load_out;
    logic                 coeff_out;
`ifdef COEFF_SERIALIZER_READBACK_EN
    logic [AddrWidth-1:0] rd_addr;
    logic [DataWidth-1:0] rd_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [DataWidth-1:0] model_bank [NCoeffs];
    logic [DataWidth-1:0] init_words [NCoeffs] = '{12'h001, 12'h7FF, 12'h800, 12'hA5A, 12'h3C3};
    logic                 exp_bits [$];

    always #5 clk = ~clk;

    coeff_serializer #(
        .DataWidth (DataWidth),
        .NTaps     (NTaps)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .load_req       (load_req),
        .fir_busy       (fir_busy),
`ifdef COEFF_SERIALIZER_READBACK_EN
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
`endif
        .busy           (busy),
        .load_done      (load_done),
        .coeff_load_out (coeff_load_out),
        .coeff_out      (coeff_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic do_wr, input logic [AddrWidth-1:0] addr,
                                 input logic [DataWidth-1:0] data, input logic do_load,
                                 input logic busy_level);
        wr_en    = do_wr;
        wr_addr  = addr;
        wr_data  = data;
        load_req = do_load;
        fir_busy = busy_level;
        tick();
        wr_en    = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic writeWord(input int addr, input logic [DataWidth-1:0] data);
        logic expect_err;
        expect_err = (addr >= NCoeffs);
        applyStimulus(1'b1, AddrWidth'(addr), data, 1'b0, 1'b0);
        checkOutput("wr_err_idle", wr_err, expect_err);
        if (!expect_err) model_bank[addr] = data;
    endtask

    // Expects the first bit already on coeff_out; optionally injects a write or a reset mid-stream.
    task automatic runStream(input int inject_at, input int reset_at);
        exp_bits.delete();
        for (int w = NCoeffs - 1; w >= 0; w--)
            for (int b = DataWidth - 1; b >= 0; b--)
                exp_bits.push_back(model_bank[w][b]);
        for (int i = 0; i < TotalBits; i++) begin
            checkOutput($sformatf("load_en_bit%0d", i), coeff_load_out, 1'b1);
            checkOutput($sformatf("coeff_bit%0d", i), coeff_out, exp_bits[i]);
            checkOutput("busy_shift", busy, 1'b1);
            checkOutput("wr_err_shift", wr_err, (inject_at >= 0) && (i == inject_at + 1));
            if (i == reset_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int k = 0; k < NCoeffs; k++) model_bank[k] = '0;
                checkOutput("rst_load_en", coeff_load_out, 1'b0);
                checkOutput("rst_coeff_out", coeff_out, 1'b0);
                checkOutput("rst_busy", busy, 1'b0);
                for (int k = 0; k < 4; k++) begin
                    checkOutput("rst_no_done", load_done, 1'b0);
                    checkOutput("rst_idle_load_en", coeff_load_out, 1'b0);
                    tick();
                end
                return;
            end
            if (i == inject_at) begin
                wr_en   = 1'b1;
                wr_addr = 3'd2;
                wr_data = DataWidth'($urandom);
            end
            tick();
            wr_en = 1'b0;
        end
        checkOutput("done_load_en", coeff_load_out, 1'b0);
        checkOutput("done_coeff_out", coeff_out, 1'b0);
        checkOutput("done_pulse", load_done, 1'b1);
        checkOutput("done_busy", busy, 1'b1);
        tick();
        checkOutput("done_pulse_end", load_done, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
    endtask

    task automatic waitThenStream(input int busy_cycles, input int inject_at);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 1; k < busy_cycles; k++) begin
            checkOutput("wait_busy", busy, 1'b1);
            checkOutput("wait_load_en", coeff_load_out, 1'b0);
            checkOutput("wait_coeff_out", coeff_out, 1'b0);
            checkOutput("wait_wr_err", wr_err, (k == 4));
            wr_en    = (k == 3);
            wr_addr  = 3'd1;
            wr_data  = 12'hFFF;
            load_req = (k == 2);
            tick();
            wr_en    = 1'b0;
            load_req = 1'b0;
        end
        checkOutput("wait_last_load_en", coeff_load_out, 1'b0);
        fir_busy = 1'b0;
        tick();
        runStream(inject_at, -1);
    endtask

`ifdef COEFF_SERIALIZER_READBACK_EN
    task automatic checkReadback();
        for (int a = 0; a < 8; a++) begin
            rd_addr = AddrWidth'(a);
            #1;
            checkOutput($sformatf("rd_data_%0d", a), rd_data, (a < NCoeffs) ? model_bank[a] : '0);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        load_req = 1'b0;
        fir_busy = 1'b0;
`ifdef COEFF_SERIALIZER_READBACK_EN
        rd_addr  = '0;
`endif
        for (int k = 0; k < NCoeffs; k++) model_bank[k] = '0;
        tick();
        tick();
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_load_en", coeff_load_out, 1'b0);
        checkOutput("reset_coeff_out", coeff_out, 1'b0);
        checkOutput("reset_done", load_done, 1'b0);
        checkOutput("reset_wr_err", wr_err, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] known-pattern download");
        for (int a = 0; a < NCoeffs; a++) writeWord(a, init_words[a]);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        runStream(-1, -1);

        $display("[TB] out-of-range writes in IDLE");
        writeWord(5, 12'h123);
        writeWord(7, 12'h456);
`ifdef COEFF_SERIALIZER_READBACK_EN
        checkReadback();
`endif

        $display("[TB] download held off by fir_busy, write during SHIFT");
        waitThenStream(20, 10);

        $display("[TB] same-cycle write and load_req");
        applyStimulus(1'b1, 3'd4, 12'h555, 1'b1, 1'b0);
        model_bank[4] = 12'h555;
        checkOutput("same_cycle_wr_err", wr_err, 1'b0);
        runStream(-1, -1);

        $display("[TB] randomized banks and busy delays");
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NCoeffs; a++) writeWord(a, DataWidth'($urandom));
            if (r % 2 == 0) begin
                applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
                runStream(-1, -1);
            end else begin
                waitThenStream(int'($urandom_range(6, 12)), int'($urandom_range(0, TotalBits - 2)));
            end
        end

        $display("[TB] reset during SHIFT");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        runStream(-1, 30);
`ifdef COEFF_SERIALIZER_READBACK_EN
        checkReadback();
`endif
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        runStream(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
